// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : RV32 instruction-fetch stage. It holds the fetch PC and queues
//               fetched words. It hands {instr, pc, pc+4} to decode through a
//               valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic        misalign_err
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(QUEUE_DEPTH);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             misalign_q, misalign_d;
    logic [31:0]      q_instr_q [QUEUE_DEPTH];
    logic [31:0]      q_instr_d [QUEUE_DEPTH];
    logic [31:0]      q_pc_q    [QUEUE_DEPTH];
    logic [31:0]      q_pc_d    [QUEUE_DEPTH];

    logic run;
    logic pop;
    logic push;
    logic redirect_take;
    logic redirect_bad;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
    end

    // ---------------- FSM: output logic ----------------
    always_comb begin
        run = 1'b0;
        case (state_q)
            ST_RUN:  run = 1'b1;
            ST_HALT: run = 1'b0;
            default: run = 1'b0;
        endcase
    end

    // Handshake and control decode
    always_comb begin
        pop           = out_valid & out_ready;
        redirect_take = run & redirect_valid;
        redirect_bad  = redirect_take & (redirect_pc[1:0] != 2'b00);
        push          = run & fetch_en & ~redirect_valid &
                        ((count_q < C_DEPTH) | pop);
    end

    // Queue control and fetch PC. A redirect flushes even if decode pops.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        misalign_d = misalign_q;
        if (redirect_take) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            if (redirect_bad) begin
                misalign_d = 1'b1;
            end else begin
                fetch_pc_d = redirect_pc;
            end
        end else begin
            if (push) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                tail_d     = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_comb begin
        q_instr_d = q_instr_q;
        q_pc_d    = q_pc_q;
        if (push) begin
            q_instr_d[tail_q] = imem_rdata;
            q_pc_d[tail_q]    = fetch_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        q_instr_q <= q_instr_d;
        q_pc_q    <= q_pc_d;
    end

    assign imem_addr    = fetch_pc_q;
    assign out_valid    = (count_q != '0);
    assign out_instr    = q_instr_q[head_q];
    assign out_pc       = q_pc_q[head_q];
    assign out_pc_plus4 = q_pc_q[head_q] + 32'd4;
    assign misalign_err = misalign_q;

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage for the single-cycle RV32 core, directly upstream of instruction_memory.
- Holds the fetch PC and drives the instruction_memory word address. Memory reads are combinational; the returned word is captured into a small instruction queue.
- Presents {instr, pc, pc+4} to decode with a valid/ready handshake.
- Handles control-flow redirects (branch/jump), stalls from decode, and misaligned-target detection.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- QUEUE_DEPTH, 2, instruction queue entries; power of two, >= 2.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- fetch_en  input  1  enables new fetches; the queue still drains when low.
- imem_addr  output  32  byte address to instruction_memory (A); always equals fetch_pc.
- imem_rdata  input  32  instruction word from instruction_memory (RD), valid in the same cycle.
- redirect_valid  input  1  one-cycle pulse: taken branch/jump.
- redirect_pc  input  32  new fetch target, sampled when redirect_valid=1.
- out_valid  output  1  queue head holds a valid instruction.
- out_ready  input  1  decode accepts the head this cycle.
- out_instr  output  32  head instruction word.
- out_pc  output  32  address of out_instr.
- out_pc_plus4  output  32  out_pc + 4 (mod 2^32).
- misalign_err  output  1  sticky flag: a redirect target had bits[1:0] != 0.

Behaviour:
- States: RUN, HALT.
- Reset (rst=1 at a clock edge):
  - fetch_pc <= RESET_PC; queue emptied (count=0, pointers=0); state <= RUN.
  - misalign_err <= 0; out_valid=0 (combinational from count).
  - Reset mid-operation discards all queued entries immediately; there is no partial-flush behaviour.
- Outputs:
  - out_valid = (count != 0).
  - out_instr, out_pc, out_pc_plus4 come from the head entry and are don't-care when out_valid=0.
  - imem_addr = fetch_pc at all times.
- pop = out_valid & out_ready.
- push = (state==RUN) & fetch_en & ~redirect_valid & ((count < QUEUE_DEPTH) | pop).
  - Push while full is allowed only when a pop happens in the same cycle.
- On push: the entry {imem_rdata, fetch_pc} is written at the tail, and fetch_pc <= fetch_pc + 4 (wraps at 2^32).
- Simultaneous push and pop: count is unchanged and both pointers advance. Pointers wrap modulo QUEUE_DEPTH.
- Redirect (redirect_valid=1, state RUN, redirect_pc[1:0]==0):
  - Queue flushed (count <= 0) in the same edge, regardless of pop or out_ready.
  - fetch_pc <= redirect_pc; no push that cycle.
  - out_valid=0 in the following cycle; the target instruction reaches the head 2 cycles after the redirect edge (push on the next edge, valid after it).
- Misaligned redirect (redirect_pc[1:0] != 0):
  - Queue flushed, misalign_err <= 1, state <= HALT; fetch_pc is unchanged.
  - In HALT there are no pushes and redirects are ignored; only rst leaves HALT.
- Redirect while in HALT: ignored, with no flush.
- fetch_en=0: no push and fetch_pc holds; pops continue; a redirect is still honoured.
- Latency:
  - First instruction after reset release: pushed on the first edge with rst=0 and fetch_en=1; out_valid=1 after that edge.
  - Steady state is one instruction per cycle when out_ready=1.
- Ordering: entries leave in fetch order; no instruction is duplicated or dropped except on flush.

Test Plan:
- Reset then stream. Memory word0=32'h0062E233, word1=32'h00B62423; fetch_en=1, out_ready=1 -> after the 1st edge out_pc=0, out_instr=0062E233, out_pc_plus4=4; next cycle out_pc=4, out_instr=00B62423; imem_addr increments by 4 per cycle.
- Backpressure. out_ready=0 for 5 cycles from reset -> count saturates at 2, fetch_pc stops at 0x8, out_pc stays 0. Raise out_ready -> heads emerge 0, 4, 8 in order with no gaps; push and pop coincide while full.
- Redirect. With 2 entries queued, pulse redirect_valid with redirect_pc=0x40 -> next cycle out_valid=0 and imem_addr=0x40; the cycle after, out_pc=0x40.
- Misaligned redirect. redirect_pc=0x42 -> misalign_err=1, out_valid=0 thereafter. A later redirect to 0x80 is ignored and imem_addr holds; rst clears misalign_err and sets imem_addr=RESET_PC.
- Fetch disable and wrap. fetch_en=0 for 3 cycles -> queue drains, imem_addr constant. Start near the top via redirect_pc=0xFFFF_FFFC -> next push gives out_pc=FFFF_FFFC, out_pc_plus4=0, and fetch_pc wraps to 0.
- Reset mid-stream. Assert rst while full and out_ready=1 -> next cycle out_valid=0, imem_addr=RESET_PC, and no stale entry appears afterwards.
